// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that sequences single-bit hold/reset/set/toggle commands
// from NREQ requesters onto one shared bank of WIDTH JK flip-flops.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [AW*NREQ-1:0]        req_addr,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      clear_req,
  output logic [WIDTH-1:0]          j_vec,
  output logic [WIDTH-1:0]          k_vec,
  output logic                      grant_valid,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [15:0]               cmd_count
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             grant_valid_q, grant_valid_d;
  logic [15:0]      cmd_count_q, cmd_count_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [1:0]       sel_op;
  logic [AW-1:0]    sel_addr;

  // Rotating search: first valid requester at or after ptr, wrapping at NREQ.
  always_comb begin : arbitrate
    int idx;
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
    if (!rst_n || clear_req) begin
      grant_found = 1'b0;
    end
  end

  assign req_ready = grant_found ? (NREQ'(1) << grant_idx) : '0;
  assign sel_op    = req_op[2*grant_idx +: 2];
  assign sel_addr  = req_addr[AW*grant_idx +: AW];

  always_comb begin : next_state
    j_d           = '0;
    k_d           = '0;
    grant_valid_d = 1'b0;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    cmd_count_d   = cmd_count_q;
    if (clear_req) begin
      k_d = '1;
    end else if (grant_found) begin
      // Out-of-range addresses match no bit, leaving J/K all zero.
      for (int b = 0; b < WIDTH; b++) begin
        if (int'(sel_addr) == b) begin
          j_d[b] = sel_op[1];
          k_d[b] = sel_op[0];
        end
      end
      grant_valid_d = 1'b1;
      grant_id_d    = grant_idx;
      ptr_d         = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
      if (cmd_count_q != 16'hFFFF) begin
        cmd_count_d = cmd_count_q + 16'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      grant_id_q    <= '0;
      j_q           <= '0;
      k_q           <= '0;
      grant_valid_q <= 1'b0;
      cmd_count_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      j_q           <= j_d;
      k_q           <= k_d;
      grant_valid_q <= grant_valid_d;
      cmd_count_q   <= cmd_count_d;
    end
  end

  assign j_vec       = j_q;
  assign k_vec       = k_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign cmd_count   = cmd_count_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed steps plus random traffic,
// compared against a rule-level model of grants, J/K pulses and a JK bank.
module tb_jk_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [11:0] req_addr;
  logic [3:0]  req_ready;
  logic        clear_req;
  logic [7:0]  j_vec;
  logic [7:0]  k_vec;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] cmd_count;

  int total = 0;
  int bad   = 0;

  // Model state
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [7:0] m_bank = '0;
  logic [7:0] exp_j  = '0;
  logic [7:0] exp_k  = '0;
  logic       exp_gv = 1'b0;
  int         exp_gid = 0;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .AW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .clear_req  (clear_req),
    .j_vec      (j_vec),
    .k_vec      (k_vec),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .cmd_count  (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The JK bank this block drives, so the end effect of commands can be observed.
  logic [7:0] bank_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= '0;
    else        bank_q <= (j_vec & ~bank_q) | (~k_vec & bank_q);
  end

  function automatic logic [7:0] jk_next(input logic [7:0] q, input logic [7:0] j, input logic [7:0] k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      case ({j[b], k[b]})
        2'b01:   r[b] = 1'b0;
        2'b10:   r[b] = 1'b1;
        2'b11:   r[b] = !q[b];
        default: r[b] = q[b];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_bank = '0;
    exp_j = '0; exp_k = '0; exp_gv = 1'b0; exp_gid = 0;
  endtask

  // One clock cycle: drive inputs just after a rising edge, check ready mid-cycle,
  // check the registered result just after the next rising edge.
  task automatic cycle(input logic [3:0] v, input logic [7:0] op, input logic [11:0] ad, input logic clr);
    int         g;
    int         a;
    int         opv;
    logic [3:0] rdy;
    req_valid = v; req_op = op; req_addr = ad; clear_req = clr;
    g = -1;
    if (!clr) begin
      for (int s = 0; s < 4; s++) begin
        if (g < 0 && v[(m_ptr + s) % 4]) g = (m_ptr + s) % 4;
      end
    end
    rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(rdy));
    m_bank = jk_next(m_bank, exp_j, exp_k);
    if (clr) begin
      exp_j = 8'h00; exp_k = 8'hFF; exp_gv = 1'b0;
    end else if (g >= 0) begin
      a   = int'(ad[3*g +: 3]);
      opv = int'(op[2*g +: 2]);
      exp_j   = (a < 8 && opv >= 2)     ? 8'(1 << a) : 8'h00;
      exp_k   = (a < 8 && opv % 2 == 1) ? 8'(1 << a) : 8'h00;
      exp_gv  = 1'b1;
      exp_gid = g;
      m_ptr   = (g + 1) % 4;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      exp_j = 8'h00; exp_k = 8'h00; exp_gv = 1'b0;
    end
    @(posedge clk); #1;
    check("j_vec", 32'(j_vec), 32'(exp_j));
    check("k_vec", 32'(k_vec), 32'(exp_k));
    check("grant_valid", 32'(grant_valid), 32'(exp_gv));
    if (exp_gv) check("grant_id", 32'(grant_id), 32'(exp_gid));
    check("cmd_count", 32'(cmd_count), 32'(m_cnt));
    check("bank", 32'(bank_q), 32'(m_bank));
  endtask

  initial begin
    int         k_run;
    logic       bit0_start;
    rst_n = 1'b0; req_valid = 4'hF; req_op = 8'hFF; req_addr = 12'h0; clear_req = 1'b0;
    model_reset();
    #3;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_j", 32'(j_vec), 32'h0);
    check("rst_k", 32'(k_vec), 32'h0);
    check("rst_count", 32'(cmd_count), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single set from requester 2 at bit 5, then an idle cycle.
    cycle(4'b0100, 8'b00_10_00_00, 12'({3'd0, 3'd5, 3'd0, 3'd0}), 1'b0);
    check("set_j_20", 32'(j_vec), 32'h20);
    cycle(4'b0000, 8'h00, 12'h000, 1'b0);

    // Reset in the middle of traffic clears outputs without a clock.
    cycle(4'b1111, 8'hAA, 12'h5A3, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'h0);
    check("midrst_j", 32'(j_vec), 32'h0);
    check("midrst_k", 32'(k_vec), 32'h0);
    check("midrst_gv", 32'(grant_valid), 32'h0);
    check("midrst_gid", 32'(grant_id), 32'h0);
    check("midrst_count", 32'(cmd_count), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fairness: all four requesters valid for eight cycles, grants 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 8'($urandom), 12'($urandom), 1'b0);
      check("rr_order", 32'(grant_id), 32'(i % 4));
    end
    check("rr_count8", 32'(cmd_count), 32'd8);

    // Clear has priority for two cycles; afterwards requester 1 wins.
    cycle(4'b1010, 8'hFF, 12'h000, 1'b1);
    cycle(4'b1010, 8'hFF, 12'h000, 1'b1);
    cycle(4'b1010, 8'hFF, 12'h000, 1'b0);
    check("clr_then_r1", 32'(grant_id), 32'd1);

    // Toggle stream: requester 1, bit 0, three consecutive transfers.
    cycle(4'b0000, 8'h00, 12'h000, 1'b0);
    bit0_start = m_bank[0];
    for (int i = 0; i < 3; i++) cycle(4'b0010, 8'b00_00_11_00, 12'h000, 1'b0);
    cycle(4'b0000, 8'h00, 12'h000, 1'b0);
    cycle(4'b0000, 8'h00, 12'h000, 1'b0);
    check("toggle_inverted", 32'(bank_q[0]), 32'(!bit0_start));

    // Hold op and reset of the top bit.
    cycle(4'b0001, 8'b00_00_00_00, 12'h000, 1'b0);
    cycle(4'b0001, 8'b00_00_00_01, 12'd7, 1'b0);
    check("reset_bit7_k", 32'(k_vec), 32'h80);

    // Random traffic with occasional clears.
    for (int i = 0; i < 40; i++) begin
      cycle(4'($urandom), 8'($urandom), 12'($urandom), 1'($urandom_range(7) == 0));
    end

    // Long run of hold commands to bring the counter up to saturation.
    m_bank = jk_next(m_bank, exp_j, exp_k);
    k_run = 65530 - m_cnt;
    req_valid = 4'b1111; req_op = 8'h00; req_addr = 12'h000; clear_req = 1'b0;
    repeat (k_run) @(posedge clk);
    #1;
    exp_gid = (m_ptr + k_run - 1) % 4;
    m_ptr   = (m_ptr + k_run) % 4;
    m_cnt   = m_cnt + k_run;
    exp_j = 8'h00; exp_k = 8'h00; exp_gv = 1'b1;
    check("preload_count", 32'(cmd_count), 32'(m_cnt));
    for (int i = 0; i < 10; i++) cycle(4'b1111, 8'h00, 12'h000, 1'b0);
    check("count_saturated", 32'(cmd_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin arbiter and command sequencer that shares one bank of `WIDTH` JK flip-flops between `NREQ` requesters. Each requester issues single-bit commands (hold / reset / set / toggle) over a valid/ready handshake. The block grants at most one command per cycle and drives registered one-cycle J/K pulse vectors into the bank. It sits between the control agents and the JK bank, and is the only driver of the bank's J and K inputs.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 8: number of JK flip-flops in the bank.
- `AW`, default 3: address width, equal to `$clog2(WIDTH)`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: per-requester command valid.
- `req_op` in `2*NREQ`: per-requester op, `{J,K}` encoding. Requester i uses bits `[2i+1:2i]`. 00 = hold, 01 = reset, 10 = set, 11 = toggle.
- `req_addr` in `AW*NREQ`: per-requester target bit. Requester i uses bits `[AW*i+AW-1:AW*i]`.
- `req_ready` out `NREQ`: combinational, one-hot or zero; grant to requester i this cycle.
- `clear_req` in 1: level; bank-wide clear request, highest priority.
- `j_vec` out `WIDTH`: registered J drive to the bank.
- `k_vec` out `WIDTH`: registered K drive to the bank.
- `grant_valid` out 1: registered; `j_vec`/`k_vec` carry a granted requester command this cycle.
- `grant_id` out `$clog2(NREQ)`: registered; index of the requester granted in the previous cycle.
- `cmd_count` out 16: number of accepted requester commands; saturates at 16'hFFFF.

## Operation
- **Round-robin pointer `ptr`:**
  - Each cycle with `clear_req`=0, grant the first `i` with `req_valid[i]`=1, searching from `ptr` upward with wrap.
  - After a grant to index g, `ptr` becomes (g+1) mod `NREQ`. With no grant, `ptr` is unchanged.
- **Handshake:** a transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1.
  - `req_ready` may depend on `req_valid`. A requester must hold op and addr stable while valid and not ready.
- **Command drive:** on the edge after a transfer of op `{a,b}` at address n:
  - `j_vec` = a<<n and `k_vec` = b<<n. All other bits are 0.
  - `grant_valid`=1 and `grant_id`=g.
- **Hold op (00):** is granted and counted, and drives `j_vec`=`k_vec`=0 with `grant_valid`=1.
- **No transfer, no clear:** next cycle `j_vec`=`k_vec`=0 (bank holds) and `grant_valid`=0.
- **`clear_req`=1:**
  - All `req_ready`=0.
  - Next cycle `j_vec`=0, `k_vec`=all ones, `grant_valid`=0.
  - `ptr` and `cmd_count` are unchanged.
  - A clear held for N cycles produces N clear cycles.
- **Address range:** if addr ≥ `WIDTH`, the command is accepted and counted but drives all-zero J/K.
- **`cmd_count`:** increments by 1 per transfer and saturates.
- **Simultaneous requests to the same address:** only the granted one executes. The others wait; the block does no merging.

## Timing
- Reset (`rst_n`=0, asynchronous): `j_vec`=0, `k_vec`=0, `grant_valid`=0, `grant_id`=0, `cmd_count`=0, `ptr`=0. `req_ready` is forced to 0 while `rst_n`=0.
- Reset mid-operation: outputs clear immediately with no clock. A command registered but not yet captured by the bank is dropped.
- First grant is possible in the first cycle with `rst_n`=1.
- Latency:
  - Transfer in cycle t gives J/K valid in cycle t+1; the bank captures at the end of t+1.
  - Back-to-back transfers every cycle are supported, so throughput is 1 command/cycle.
- `req_ready` is purely combinational from `req_valid`, `clear_req`, `ptr` and `rst_n`. There is no combinational path from any input to `j_vec`/`k_vec`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with pending commands → all outputs 0 immediately. After release, requester 0 alone is granted first.
- **Single set:** requester 2 only, op=10, addr=5 → `req_ready`=4'b0100 that cycle. Next cycle `j_vec`=8'h20, `k_vec`=0, `grant_id`=2, `grant_valid`=1. Following cycle all zero; `cmd_count`=1.
- **Round-robin fairness:** all 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3 and `cmd_count`=8.
- **Clear priority:** requesters 1 and 3 valid with `clear_req`=1 for 2 cycles → no `req_ready`, two cycles of `k_vec`=8'hFF, `j_vec`=0. After release, requester 1 is granted first (`ptr` unchanged at 0).
- **Toggle streaming:** requester 1 alone, op=11, addr=0, valid for 3 cycles → 3 transfers and 3 consecutive cycles of `j_vec`=`k_vec`=8'h01. The bank bit ends inverted from its start (odd toggles).
- **Edge ops:**
  - op=00 → `grant_valid`=1 with J=K=0, and `cmd_count` increments.
  - addr=7 reset → `k_vec`=8'h80.
  - `cmd_count` preloaded near 16'hFFFF via long run → saturates at 16'hFFFF.
